// File: rtl/fifo_frame_unpacker_pkg.sv
// Shared constants and types for the FIFO frame unpacker.
// Frame layout: [139:136] beat count, [135:128] reserved, [127:0] payload.
package fifo_frame_unpacker_pkg;

    localparam int FRAME_W     = 140;
    localparam int BEAT_W      = 16;
    localparam int MAX_BEATS   = 8;
    localparam int PAYLOAD_W   = BEAT_W * MAX_BEATS;
    localparam int CNT_W       = 8;
    localparam int BEAT_CNT_W  = 4;

    localparam int N_MSB       = 139;
    localparam int N_LSB       = 136;
    localparam int PAYLOAD_MSB = 127;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_frame_unpacker_frame_hdr_check.sv
// Header decoder: decides whether a frame's beat count is usable and
// passes the count through for loading the remaining-beat counter.
module frame_hdr_check
    import fifo_frame_unpacker_pkg::*;
(
    input  logic [BEAT_CNT_W-1:0] n_field,
    output logic                  frame_ok,
    output logic [BEAT_CNT_W-1:0] beat_count
);

    // A frame is well formed only for 1..MAX_BEATS beats.
    always_comb begin
        frame_ok   = (n_field != '0) && (n_field <= BEAT_CNT_W'(MAX_BEATS));
        beat_count = n_field;
    end

endmodule

// File: rtl/fifo_frame_unpacker.sv
// Pops 140-bit frames from a show-ahead FIFO and replays the payload as a
// 16-bit valid/ready beat stream; malformed frames are dropped and counted.
module fifo_frame_unpacker
    import fifo_frame_unpacker_pkg::*;
(
    input  logic               clk_out,
    input  logic               rst,
    input  logic               fifo_empty,
    input  logic [FRAME_W-1:0] data_from_fifo,
    output logic               fifo_r_enable,
    output logic [BEAT_W-1:0]  dout,
    output logic               dout_valid,
    output logic               dout_last,
    input  logic               dout_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   drop_cnt
);

    state_t                state_q, state_d;
    logic [PAYLOAD_W-1:0]  shift_q, shift_d;
    logic [BEAT_CNT_W-1:0] beats_q, beats_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;

    logic                  frame_ok;
    logic [BEAT_CNT_W-1:0] beat_count;
    logic                  last_hs;
    logic                  unused_reserved;

    // The reserved header byte carries nothing for this consumer.
    assign unused_reserved = ^data_from_fifo[N_LSB-1:PAYLOAD_MSB+1];

    frame_hdr_check u_hdr_check (
        .n_field    (data_from_fifo[N_MSB:N_LSB]),
        .frame_ok   (frame_ok),
        .beat_count (beat_count)
    );

    // Output decode and pop strobe; a pop is held off while reset is asserted.
    always_comb begin
        dout_valid    = (state_q == SEND);
        busy          = (state_q == SEND);
        dout_last     = dout_valid && (beats_q == BEAT_CNT_W'(1));
        dout          = dout_valid ? shift_q[PAYLOAD_MSB -: BEAT_W] : '0;
        last_hs       = dout_valid && dout_ready && dout_last;
        fifo_r_enable = !rst && !fifo_empty && ((state_q == IDLE) || last_hs);
    end

    // Next-state: advance on handshakes, then let a pop overwrite the frame.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        beats_d    = beats_q;
        drop_cnt_d = drop_cnt_q;

        if ((state_q == SEND) && dout_ready) begin
            if (beats_q != BEAT_CNT_W'(1)) begin
                shift_d = {shift_q[PAYLOAD_W-BEAT_W-1:0], {BEAT_W{1'b0}}};
                beats_d = beats_q - BEAT_CNT_W'(1);
            end else begin
                state_d = IDLE;
            end
        end

        if (fifo_r_enable) begin
            shift_d = data_from_fifo[PAYLOAD_MSB:0];
            beats_d = beat_count;
            if (frame_ok) begin
                state_d = SEND;
            end else begin
                state_d = IDLE;
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            beats_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            beats_q    <= beats_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fifo_frame_unpacker.sv
// Self-checking bench for fifo_frame_unpacker: a FIFO model feeds frames,
// a beat-queue reference model predicts the stream and pop strobes.
module tb_fifo_frame_unpacker;

    logic         clk_out = 1'b0;
    logic         rst;
    logic         fifo_empty;
    logic [139:0] data_from_fifo;
    logic         fifo_r_enable;
    logic [15:0]  dout;
    logic         dout_valid;
    logic         dout_last;
    logic         dout_ready;
    logic         busy;
    logic [7:0]   drop_cnt;

    typedef struct {
        logic [15:0] beat;
        logic        last;
    } beat_t;

    logic [139:0] fifo_q [$];
    beat_t        exp_q  [$];
    logic [15:0]  hs_log [$];
    int           model_drops;
    int           dut_pops;
    int           vectors;
    int           miscompares;

    fifo_frame_unpacker dut (
        .clk_out        (clk_out),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .data_from_fifo (data_from_fifo),
        .fifo_r_enable  (fifo_r_enable),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .dout_last      (dout_last),
        .dout_ready     (dout_ready),
        .busy           (busy),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk_out = ~clk_out;

    function automatic logic [139:0] makeFrame(input logic [3:0] n, input logic [127:0] payload);
        logic [7:0] rsv;
        rsv = 8'($urandom);
        return {n, rsv, payload};
    endfunction

    function automatic logic [127:0] randPayload();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic applyStimulus(input bit ready);
        bit          hs;
        bit          pop;
        logic [139:0] f;
        int          n;
        logic [15:0] seen;
        @(negedge clk_out);
        dout_ready     = ready;
        fifo_empty     = (fifo_q.size() == 0);
        data_from_fifo = fifo_empty ? makeFrame(4'($urandom), randPayload()) : fifo_q[0];
        #1;
        hs  = (exp_q.size() != 0) && ready;
        pop = !fifo_empty && ((exp_q.size() == 0) || ((exp_q.size() == 1) && ready));
        checkOutput("dout_valid", 32'(dout_valid), 32'(exp_q.size() != 0));
        checkOutput("busy", 32'(busy), 32'(exp_q.size() != 0));
        checkOutput("fifo_r_enable", 32'(fifo_r_enable), 32'(pop));
        checkOutput("drop_cnt", 32'(drop_cnt), 32'(model_drops));
        if (exp_q.size() != 0) begin
            checkOutput("dout", 32'(dout), 32'(exp_q[0].beat));
            checkOutput("dout_last", 32'(dout_last), 32'(exp_q[0].last));
        end else begin
            checkOutput("dout_idle", 32'(dout), 32'h0);
            checkOutput("dout_last_idle", 32'(dout_last), 32'h0);
        end
        if (fifo_r_enable) dut_pops++;
        seen = dout;
        @(posedge clk_out);
        if (hs) begin
            hs_log.push_back(seen);
            void'(exp_q.pop_front());
        end
        if (pop) begin
            f = fifo_q.pop_front();
            n = int'(f[139:136]);
            if (n >= 1 && n <= 8) begin
                for (int i = 0; i < n; i++) begin
                    exp_q.push_back('{beat: f[127 - 16*i -: 16], last: (i == n - 1)});
                end
            end else if (model_drops < 255) begin
                model_drops++;
            end
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && k < budget) begin
            applyStimulus(1'b1);
            k++;
        end
        checkOutput("drain_timeout", 32'(exp_q.size() + fifo_q.size()), 32'h0);
    endtask

    initial begin
        logic [127:0] p;
        bit           pat [4];
        int           k;
        vectors     = 0;
        miscompares = 0;
        model_drops = 0;
        dut_pops    = 0;
        rst            = 1'b1;
        fifo_empty     = 1'b1;
        data_from_fifo = '0;
        dout_ready     = 1'b0;
        #1;
        checkOutput("reset_valid", 32'(dout_valid), 32'h0);
        checkOutput("reset_dout", 32'(dout), 32'h0);
        checkOutput("reset_last", 32'(dout_last), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_drop", 32'(drop_cnt), 32'h0);
        checkOutput("reset_ren", 32'(fifo_r_enable), 32'h0);
        @(negedge clk_out);
        @(negedge clk_out);
        rst = 1'b0;

        $display("[TB] single N=8 frame");
        p = {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
        fifo_q.push_back(makeFrame(4'd8, p));
        hs_log.delete();
        dut_pops = 0;
        for (int i = 0; i < 9; i++) applyStimulus(1'b1);
        checkOutput("t1_beats", 32'(hs_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < hs_log.size(); i++) checkOutput("t1_beat", 32'(hs_log[i]), 32'(i + 1));
        checkOutput("t1_pops", 32'(dut_pops), 32'd1);
        drain(20);

        $display("[TB] back-to-back N=3 then N=2");
        fifo_q.push_back(makeFrame(4'd3, {16'h0A01, 16'h0A02, 16'h0A03, 80'h0}));
        fifo_q.push_back(makeFrame(4'd2, {16'h0B01, 16'h0B02, 96'h0}));
        hs_log.delete();
        dut_pops = 0;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1);
        checkOutput("t2_beats", 32'(hs_log.size()), 32'd5);
        if (hs_log.size() == 5) begin
            checkOutput("t2_beat3", 32'(hs_log[2]), 32'h0A03);
            checkOutput("t2_beat4", 32'(hs_log[3]), 32'h0B01);
        end
        checkOutput("t2_pops", 32'(dut_pops), 32'd2);
        drain(20);

        $display("[TB] backpressure N=4");
        fifo_q.push_back(makeFrame(4'd4, {16'h1111, 16'h2222, 16'h3333, 16'h4444, 64'h0}));
        hs_log.delete();
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        applyStimulus(1'b1);
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            applyStimulus(pat[k % 4]);
            k++;
        end
        checkOutput("t3_beats", 32'(hs_log.size()), 32'd4);
        if (hs_log.size() == 4) checkOutput("t3_last", 32'(hs_log[3]), 32'h4444);
        drain(20);

        $display("[TB] malformed frames then N=1");
        fifo_q.push_back(makeFrame(4'd0, randPayload()));
        fifo_q.push_back(makeFrame(4'd9, randPayload()));
        fifo_q.push_back(makeFrame(4'd1, {16'hABCD, 112'h0}));
        hs_log.delete();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1);
        checkOutput("t4_drops", 32'(drop_cnt), 32'd2);
        checkOutput("t4_beats", 32'(hs_log.size()), 32'd1);
        if (hs_log.size() == 1) checkOutput("t4_beat", 32'(hs_log[0]), 32'hABCD);
        drain(20);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 6) begin
                if ($urandom_range(0, 4) == 0)
                    fifo_q.push_back(makeFrame(($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15)), randPayload()));
                else
                    fifo_q.push_back(makeFrame(4'($urandom_range(1, 8)), randPayload()));
            end
            applyStimulus(1'($urandom_range(0, 3) != 0));
        end
        drain(200);

        $display("[TB] drop counter saturation");
        for (int i = 0; i < 260; i++) fifo_q.push_back(makeFrame(($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15)), randPayload()));
        drain(300);
        applyStimulus(1'b1);
        checkOutput("t5_drop_sat", 32'(drop_cnt), 32'd255);

        $display("[TB] reset mid-frame");
        fifo_q.push_back(makeFrame(4'd8, randPayload()));
        for (int i = 0; i < 3; i++) applyStimulus(1'b1);
        @(negedge clk_out);
        fifo_q.push_back(makeFrame(4'd2, randPayload()));
        fifo_empty     = 1'b0;
        data_from_fifo = fifo_q[0];
        rst            = 1'b1;
        #1;
        checkOutput("t6_valid", 32'(dout_valid), 32'h0);
        checkOutput("t6_dout", 32'(dout), 32'h0);
        checkOutput("t6_last", 32'(dout_last), 32'h0);
        checkOutput("t6_busy", 32'(busy), 32'h0);
        checkOutput("t6_ren_in_reset", 32'(fifo_r_enable), 32'h0);
        checkOutput("t6_drop", 32'(drop_cnt), 32'h0);
        fifo_q.delete();
        exp_q.delete();
        model_drops = 0;
        @(negedge clk_out);
        fifo_empty = 1'b1;
        rst        = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_frame_unpacker.md
Name: fifo_frame_unpacker

Overview:
Read-side consumer of the 140-bit clock-crossing FIFO. Runs in the read clock domain. Pops one 140-bit frame at a time and unpacks it into a 16-bit valid/ready beat stream with a last flag. Malformed frames are dropped and counted.

Parameters:
FRAME_W, 140, FIFO entry width; fixed layout below.
BEAT_W, 16, output beat width.
MAX_BEATS, 8, payload beats per frame; payload width = BEAT_W*MAX_BEATS = 128.
CNT_W, 8, width of the drop counter.

Ports:
clk_out  in  1  read-domain clock; the only clock.
rst  in  1  asynchronous, active-high reset.
fifo_empty  in  1  FIFO empty flag; data_from_fifo is valid whenever low (show-ahead).
data_from_fifo  in  140  head-of-FIFO frame.
fifo_r_enable  out  1  pop strobe; FIFO advances on the clk_out edge where it is high.
dout  out  16  current beat.
dout_valid  out  1  beat valid.
dout_last  out  1  final beat of the frame; qualified by dout_valid.
dout_ready  in  1  downstream accept.
busy  out  1  high while a frame is held (state SEND).
drop_cnt  out  8  saturating count of dropped frames.

Behaviour:
- Frame layout: [139:136] = beat count N; [135:128] reserved, ignored; [127:0] = payload. Beat 0 = payload[127:112], then descending 16-bit slices.
- Valid N is 1..8. N=0 or N>8 is malformed.
- Reset (async, rst=1): state IDLE; fifo_r_enable=0, dout=0, dout_valid=0, dout_last=0, busy=0, drop_cnt=0; shift register and beat counter cleared.
- fifo_r_enable is combinational and is never high while fifo_empty=1. It is high in exactly two cases:
  (a) state IDLE and !fifo_empty;
  (b) state SEND, the last beat is handshaking (dout_valid & dout_ready & dout_last), and !fifo_empty.
- On a pop edge, data_from_fifo is captured in the same edge:
  - payload into a 128-bit shift register;
  - remaining-beat counter set to N.
- State machine: IDLE and SEND only.
  - IDLE, pop of a valid frame: go to SEND.
  - IDLE, pop of a malformed frame: stay in IDLE; drop_cnt increments (saturates at 255); nothing is emitted. Consecutive malformed frames are popped one per cycle.
  - SEND: dout_valid=1; dout = shift register [127:112]; dout_last = (counter==1).
  - SEND, handshake on a non-last beat: shift left by 16; counter decrements.
  - SEND, handshake on the last beat: pop if !fifo_empty and handle the new frame as in IDLE. Valid frame: stay in SEND (back-to-back, no bubble). Malformed frame: go to IDLE. FIFO empty: go to IDLE.
- dout and dout_last are held stable while dout_valid=1 and dout_ready=0. dout_valid never drops without a handshake.
- dout is zero whenever dout_valid=0.
- Latency: 1 cycle from the pop edge to the first beat valid. Throughput: 1 beat/cycle with dout_ready held high, including across frame boundaries.
- An N=1 frame emits a single beat with dout_last=1.
- Reset asserted mid-frame aborts the frame immediately. No further pop occurs until reset is released; the partial frame is lost and is not counted.

Decomposition:
- Shared package holds: frame field positions (N_MSB=139, N_LSB=136, PAYLOAD_MSB=127); BEAT_W and MAX_BEATS constants; the two-state enum (IDLE, SEND).
- One sub-module: frame_hdr_check. Combinational; maps the 4-bit N to frame_ok and beat_count; used at the pop edge.
- Counter saturation and the shift register stay in the top module.

Test Plan:
1. Single frame N=8, payload 0x0001_0002_..._0008, dout_ready=1 -> eight beats 0x0001..0x0008 on consecutive cycles; dout_last only on 0x0008; exactly one fifo_r_enable pulse.
2. Two queued frames, N=3 then N=2, dout_ready=1 -> five consecutive valid cycles with no bubble; dout_last on beats 3 and 5; second pop coincides with the beat-3 handshake.
3. Backpressure: N=4, dout_ready toggling 1,0,0,1,... -> each beat held stable while dout_ready=0; no skipped or duplicated beats; last beat reached only after 4 handshakes.
4. Malformed frames N=0 then N=9, followed by valid N=1 with payload[127:112]=0xABCD -> drop_cnt=2; only beat 0xABCD is emitted, with dout_last=1.
5. drop_cnt saturation: 260 malformed frames -> drop_cnt stops at 255 and does not wrap.
6. rst asserted after beat 2 of an N=8 frame -> outputs are zero in the same cycle and state is IDLE; after release with fifo_empty=1, fifo_r_enable stays 0.
